mdr_mem_port: RTL and testbench

Parametrised memory data register with a built-in memory handshake port. It holds the datapath's MDR value, loads it from the bus or from memory, and runs byte/halfword/word reads and writes against a variable-latency memory. Read data is sign- or zero-extended, and write data is steered onto byte lanes. It sits between the internal bus (BusMuxOut/BusMuxIn) and the memory interface, under control-unit strobes.

---
 rtl/mdr_pkg.sv | 20 ++
 rtl/mdr_lane_unit.sv | 60 ++++++
 rtl/mdr_mem_port.sv | 159 +++++++++++++++
 tb/tb_mdr_mem_port.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// Shared encodings for the memory data register port: access sizes,
// handshake FSM states and the default timeout.
package mdr_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_t;

    localparam int MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/mdr_lane_unit.sv
// Combinational byte-lane logic: read-side lane extract with sign/zero
// extension, write-side lane replication, byte enables and alignment check.
module mdr_lane_unit
    import mdr_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OFS_W      = $clog2(DATA_WIDTH/8)
) (
    input  logic [1:0]              rd_size,
    input  logic                    rd_signed,
    input  logic [OFS_W-1:0]        rd_ofs,
    input  logic [DATA_WIDTH-1:0]   rdata,
    output logic [DATA_WIDTH-1:0]   rd_ext,
    input  logic [1:0]              wr_size,
    input  logic [OFS_W-1:0]        wr_ofs,
    input  logic [DATA_WIDTH-1:0]   wr_src,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_be,
    output logic                    legal
);

    localparam int NB = DATA_WIDTH/8;

    logic [DATA_WIDTH-1:0] shifted;

    // Word reads only ever reach here with offset 0, so the shifted value is the word itself.
    always_comb begin
        shifted = rdata >> {rd_ofs, 3'b000};
        case (size_t'(rd_size))
            SZ_BYTE: rd_ext = {{(DATA_WIDTH-8){rd_signed & shifted[7]}}, shifted[7:0]};
            SZ_HALF: rd_ext = {{(DATA_WIDTH-16){rd_signed & shifted[15]}}, shifted[15:0]};
            default: rd_ext = shifted;
        endcase
    end

    always_comb begin
        wr_data = '0;
        wr_be   = '0;
        legal   = 1'b0;
        case (size_t'(wr_size))
            SZ_BYTE: begin
                wr_data = {NB{wr_src[7:0]}};
                wr_be   = NB'(1) << wr_ofs;
                legal   = 1'b1;
            end
            SZ_HALF: begin
                wr_data = {(NB/2){wr_src[15:0]}};
                wr_be   = NB'(3) << wr_ofs;
                legal   = ~wr_ofs[0];
            end
            SZ_WORD: begin
                wr_data = wr_src;
                wr_be   = '1;
                legal   = (wr_ofs == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdr_mem_port.sv
// Memory data register with a request/ack memory port: bus loads, sized
// reads with extension, lane-steered writes, and an ack timeout.
module mdr_mem_port
    import mdr_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    OFS_W      = $clog2(DATA_WIDTH/8),
    parameter int                    MAX_WAIT   = MAX_WAIT_DEFAULT,
    parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
    input  logic                    Clock,
    input  logic                    Clear,
    input  logic                    MDRin,
    input  logic                    Read,
    input  logic                    Write,
    input  logic [1:0]              Size,
    input  logic                    Signed,
    input  logic [OFS_W-1:0]        Addr_lo,
    input  logic [DATA_WIDTH-1:0]   BusMuxOut,
    output logic [DATA_WIDTH-1:0]   BusMuxIn,
    output logic                    Mem_req,
    output logic                    Mem_we,
    output logic [DATA_WIDTH/8-1:0] Mem_be,
    output logic [DATA_WIDTH-1:0]   Mem_wdata,
    input  logic [DATA_WIDTH-1:0]   Mem_rdata,
    input  logic                    Mem_ack,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Err
);

    localparam int         NB        = DATA_WIDTH/8;
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t                state, nstate;
    logic [DATA_WIDTH-1:0] mdr;
    logic                  err;
    logic [7:0]            wait_cnt;
    logic [1:0]            cmd_size;
    logic                  cmd_signed;
    logic [OFS_W-1:0]      cmd_ofs;
    logic                  cmd_write;

    logic [DATA_WIDTH-1:0] rd_ext, wr_data;
    logic [NB-1:0]         wr_be;
    logic                  legal;
    logic                  cmd_start, cmd_ok;

    logic                  req_d, we_d, busy_d, done_d;
    logic [NB-1:0]         be_d;
    logic [DATA_WIDTH-1:0] wdata_d;

    mdr_lane_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFS_W      (OFS_W)
    ) u_lane (
        .rd_size   (cmd_size),
        .rd_signed (cmd_signed),
        .rd_ofs    (cmd_ofs),
        .rdata     (Mem_rdata),
        .rd_ext    (rd_ext),
        .wr_size   (Size),
        .wr_ofs    (Addr_lo),
        .wr_src    (mdr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .legal     (legal)
    );

    assign cmd_start = (state == ST_IDLE) && (Read || Write);
    assign cmd_ok    = cmd_start && (Read != Write) && legal;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state <= ST_IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE: if (cmd_start) nstate = cmd_ok ? ST_REQ : ST_DONE;
            ST_REQ:  if (Mem_ack || wait_cnt == WAIT_LAST) nstate = ST_DONE;
            ST_DONE: nstate = ST_IDLE;
            default: nstate = ST_IDLE;
        endcase
    end

    // Port outputs are registered; lane controls are captured at accept and held through REQ.
    always_comb begin
        req_d   = (nstate == ST_REQ);
        busy_d  = (nstate != ST_IDLE);
        done_d  = (nstate == ST_DONE);
        we_d    = 1'b0;
        be_d    = '0;
        wdata_d = '0;
        if (cmd_ok) begin
            we_d    = Write;
            be_d    = wr_be;
            wdata_d = Write ? wr_data : '0;
        end else if (state == ST_REQ && nstate == ST_REQ) begin
            we_d    = Mem_we;
            be_d    = Mem_be;
            wdata_d = Mem_wdata;
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            Mem_req   <= 1'b0;
            Mem_we    <= 1'b0;
            Mem_be    <= '0;
            Mem_wdata <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Mem_req   <= req_d;
            Mem_we    <= we_d;
            Mem_be    <= be_d;
            Mem_wdata <= wdata_d;
            Busy      <= busy_d;
            Done      <= done_d;
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            cmd_size   <= '0;
            cmd_signed <= 1'b0;
            cmd_ofs    <= '0;
            cmd_write  <= 1'b0;
            err        <= 1'b0;
            wait_cnt   <= '0;
        end else if (cmd_start) begin
            cmd_size   <= Size;
            cmd_signed <= Signed;
            cmd_ofs    <= Addr_lo;
            cmd_write  <= Write;
            err        <= ~cmd_ok;
            wait_cnt   <= '0;
        end else if (state == ST_REQ && !Mem_ack) begin
            if (wait_cnt == WAIT_LAST) err <= 1'b1;
            else                       wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // A read ack beats everything; bus loads only when no command is being taken.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear)
            mdr <= INIT;
        else if (state == ST_REQ && Mem_ack && !cmd_write)
            mdr <= rd_ext;
        else if (MDRin && !cmd_start && state != ST_REQ)
            mdr <= BusMuxOut;
    end

    assign BusMuxIn = mdr;
    assign Err      = err;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Randomised bench for mdr_mem_port against a transaction-level reference
// model of the MDR, error flag and memory port behaviour.
module tb_mdr_mem_port;

    localparam int          DW     = 32;
    localparam int          NB     = 4;
    localparam int          MAXW   = 4;
    localparam logic [31:0] INIT_V = 32'h1234_5678;

    logic          Clock, Clear, MDRin, Read, Write, Signed, Mem_ack;
    logic          Mem_req, Mem_we, Busy, Done, Err;
    logic [1:0]    Size, Addr_lo;
    logic [DW-1:0] BusMuxOut, BusMuxIn, Mem_wdata, Mem_rdata;
    logic [NB-1:0] Mem_be;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdr_m;
    logic        err_m;
    bit          done_load_en = 0;

    mdr_mem_port #(
        .DATA_WIDTH (DW),
        .MAX_WAIT   (MAXW),
        .INIT       (INIT_V)
    ) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .MDRin     (MDRin),
        .Read      (Read),
        .Write     (Write),
        .Size      (Size),
        .Signed    (Signed),
        .Addr_lo   (Addr_lo),
        .BusMuxOut (BusMuxOut),
        .BusMuxIn  (BusMuxIn),
        .Mem_req   (Mem_req),
        .Mem_we    (Mem_we),
        .Mem_be    (Mem_be),
        .Mem_wdata (Mem_wdata),
        .Mem_rdata (Mem_rdata),
        .Mem_ack   (Mem_ack),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input bit rd, input bit wr, input int sz, input int ofs);
        if (rd == wr) return 0;
        if (sz == 3) return 0;
        if (sz == 1 && (ofs % 2) != 0) return 0;
        if (sz == 2 && ofs != 0) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] read_val(input int sz, input bit sgn, input int ofs,
                                             input logic [31:0] rdata);
        int          bits;
        logic [63:0] mask, lane;
        bits = (sz == 0) ? 8 : (sz == 1) ? 16 : 32;
        mask = (64'd1 << bits) - 64'd1;
        lane = ({32'd0, rdata} >> (8 * ofs)) & mask;
        if (sgn && bits < 32 && lane[bits-1]) lane = lane | ~mask;
        return lane[31:0];
    endfunction

    task automatic load(input logic [31:0] v);
        MDRin = 1'b1; BusMuxOut = v;
        @(negedge Clock);
        MDRin = 1'b0;
        mdr_m = v;
        chk("load_mdr", BusMuxIn, mdr_m);
        chk("load_err", Err, err_m);
    endtask

    task automatic idle_ack();
        Mem_ack = 1'b1; Mem_rdata = $urandom;
        @(negedge Clock);
        Mem_ack = 1'b0;
        chk("idle_ack_mdr", BusMuxIn, mdr_m);
        chk("idle_ack_req", Mem_req, 0);
        chk("idle_ack_busy", Busy, 0);
    endtask

    // One command from IDLE through DONE back to IDLE; delay = wait cycles before ack.
    task automatic txn(input bit rd, input bit wr, input int sz, input bit sgn, input int ofs,
                       input logic [31:0] rdata, input int delay);
        bit          ok, tmo;
        int          n;
        logic [3:0]  be_e;
        logic [31:0] wd_e;
        ok  = is_legal(rd, wr, sz, ofs);
        tmo = 0;
        be_e = (sz == 0) ? 4'(1 << ofs) : (sz == 1) ? 4'(3 << ofs) : 4'hF;
        wd_e = (sz == 0) ? {24'd0, mdr_m[7:0]} * 32'h0101_0101 :
               (sz == 1) ? {16'd0, mdr_m[15:0]} * 32'h0001_0001 : mdr_m;
        Read = rd; Write = wr; Size = 2'(sz); Signed = sgn; Addr_lo = 2'(ofs);
        MDRin = 1'b1; BusMuxOut = $urandom; Mem_ack = 1'b0;
        @(negedge Clock);
        Read = 1'b0; Write = 1'b0; MDRin = 1'b0;
        if (!ok) begin
            chk("bad_req", Mem_req, 0);
            chk("bad_done", Done, 1);
            chk("bad_busy", Busy, 1);
            chk("bad_err", Err, 1);
            chk("bad_mdr", BusMuxIn, mdr_m);
        end else begin
            tmo = (delay + 1 > MAXW);
            n   = tmo ? MAXW : delay + 1;
            for (int k = 1; k <= n; k++) begin
                chk("req", Mem_req, 1);
                chk("req_we", Mem_we, wr);
                chk("req_be", Mem_be, be_e);
                if (wr) chk("req_wdata", Mem_wdata, wd_e);
                chk("req_busy", Busy, 1);
                chk("req_done", Done, 0);
                chk("req_err", Err, 0);
                Read = 1'($urandom); Write = 1'($urandom); MDRin = 1'($urandom);
                BusMuxOut = $urandom;
                Mem_ack   = (k == delay + 1);
                Mem_rdata = (k == delay + 1) ? rdata : $urandom;
                @(negedge Clock);
            end
            Read = 1'b0; Write = 1'b0; MDRin = 1'b0; Mem_ack = 1'b0;
            if (rd && !tmo) mdr_m = read_val(sz, sgn, ofs, rdata);
            chk("fin_req", Mem_req, 0);
            chk("fin_done", Done, 1);
            chk("fin_busy", Busy, 1);
            chk("fin_err", Err, tmo);
            chk("fin_mdr", BusMuxIn, mdr_m);
        end
        err_m = !ok || tmo;
        if (done_load_en && $urandom_range(0, 1) == 1) begin
            MDRin = 1'b1; BusMuxOut = $urandom; mdr_m = BusMuxOut;
        end
        @(negedge Clock);
        MDRin = 1'b0;
        chk("idle_busy", Busy, 0);
        chk("idle_done", Done, 0);
        chk("idle_req", Mem_req, 0);
        chk("idle_err", Err, err_m);
        chk("idle_mdr", BusMuxIn, mdr_m);
    endtask

    task automatic reset_mid_req();
        Read = 1'b1; Size = 2'b10; Addr_lo = 2'd0; Signed = 1'b0; Mem_ack = 1'b0;
        @(negedge Clock);
        Read = 1'b0;
        @(negedge Clock);
        chk("pre_rst_req", Mem_req, 1);
        #2 Clear = 1'b0;
        #1;
        chk("rst_req", Mem_req, 0);
        chk("rst_mdr", BusMuxIn, INIT_V);
        chk("rst_busy", Busy, 0);
        chk("rst_err", Err, 0);
        chk("rst_done", Done, 0);
        chk("rst_be", Mem_be, 0);
        @(negedge Clock);
        Clear = 1'b1;
        mdr_m = INIT_V; err_m = 1'b0;
        @(negedge Clock);
        chk("post_rst_req", Mem_req, 0);
    endtask

    initial begin
        int r;
        bit rd, wr;
        Clear = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0; Size = 2'b00;
        Signed = 1'b0; Addr_lo = 2'd0; BusMuxOut = '0; Mem_rdata = '0; Mem_ack = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        chk("reset_mdr", BusMuxIn, INIT_V);
        chk("reset_req", Mem_req, 0);
        chk("reset_we", Mem_we, 0);
        chk("reset_be", Mem_be, 0);
        chk("reset_wdata", Mem_wdata, 0);
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_err", Err, 0);
        Clear = 1'b1;
        mdr_m = INIT_V; err_m = 1'b0;
        @(negedge Clock);

        txn(1, 0, 0, 1, 2, 32'h1280_3456, 3);
        chk("sbyte_val", BusMuxIn, 32'hFFFF_FF80);
        txn(1, 0, 1, 0, 2, 32'h8001_0000, 0);
        chk("uhalf_val", BusMuxIn, 32'h0000_8001);
        load(32'hDEAD_BEEF);
        txn(0, 1, 0, 0, 1, 32'h0BAD_0BAD, 0);
        chk("bwr_mdr", BusMuxIn, 32'hDEAD_BEEF);
        txn(1, 0, 2, 0, 2, 32'h7777_7777, 0);
        txn(1, 1, 0, 0, 0, 32'h7777_7777, 0);
        load(32'hCAFE_F00D);
        txn(1, 0, 2, 0, 0, 32'h1111_1111, 20);
        chk("tmo_mdr", BusMuxIn, 32'hCAFE_F00D);
        txn(1, 0, 2, 0, 0, 32'hA5A5_5A5A, MAXW - 1);
        chk("tie_mdr", BusMuxIn, 32'hA5A5_5A5A);
        chk("tie_err", Err, 0);
        idle_ack();
        reset_mid_req();

        done_load_en = 1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) load($urandom);
            if ($urandom_range(0, 7) == 0) idle_ack();
            r  = $urandom_range(0, 9);
            rd = (r < 4) || (r >= 8);
            wr = (r >= 4 && r < 9);
            txn(rd, wr, $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
                $urandom, $urandom_range(0, 5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
